// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit multiplexed seven-segment scan controller.
// The digits are shown one at a time in SHOW slots of REFRESH_DIV cycles.
// Each SHOW slot is followed by a BLANK slot of BLANK_CYCLES cycles with every
// anode off. A newly loaded value is held in a shadow register and only reaches
// the display at a frame boundary, so a frame never shows two different values.
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous reset, active low
//   load       - one-cycle capture strobe for din (ignored while hold=1)
//   din[15:0]  - four hex nibbles, nibble i drives digit i
//   hold       - freezes the shadow value
//   out[6:0]   - segments {g,f,e,d,c,b,a}, active low, registered
//   enable[3:0]- digit anodes, active low, registered
//   frame_tick - one-cycle pulse on the first output cycle of each digit-0 slot
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        hold,
  output logic [6:0]  out,
  output logic [3:0]  enable,
  output logic        frame_tick
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enter_show;
  logic             frame_boundary;

  logic [15:0] pending_q, pending_d;
  logic [15:0] disp_q, disp_d;
  logic        dirty_q, dirty_d;

  logic [6:0]  out_q, out_d;
  logic [3:0]  enable_q, enable_d;
  logic        frame_tick_q, frame_tick_d;
  logic [3:0]  cur_nib;
  logic        suppressed;

  // Active-low seven-segment decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Scheduler state register; reset parks in BLANK of digit 3 so digit 0 comes next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BLANK;
      idx_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scheduler next-state: SHOW slot, optional BLANK slot, then next digit.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + CNT_W'(1);
    enter_show = 1'b0;
    case (state_q)
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0) begin
            idx_d      = idx_q + 2'd1;
            enter_show = 1'b1;
          end else begin
            state_d = ST_BLANK;
          end
        end
      end
      ST_BLANK: begin
        if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
          state_d    = ST_SHOW;
          idx_d      = idx_q + 2'd1;
          cnt_d      = '0;
          enter_show = 1'b1;
        end
      end
      default: begin
        state_d = ST_BLANK;
      end
    endcase
  end

  assign frame_boundary = enter_show && (idx_d == 2'd0);

  // Shadow update: a load at the boundary lands in pending and stays dirty,
  // while disp takes the value that was pending before the load.
  always_comb begin
    pending_d = pending_q;
    disp_d    = disp_q;
    dirty_d   = dirty_q;
    if (frame_boundary && dirty_q) begin
      disp_d  = pending_q;
      dirty_d = 1'b0;
    end
    if (load && !hold) begin
      pending_d = din;
      dirty_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      disp_q    <= '0;
      dirty_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      disp_q    <= disp_d;
      dirty_q   <= dirty_d;
    end
  end

  // Output decode from the current scheduler state.
  always_comb begin
    out_d        = 7'h7F;
    enable_d     = 4'hF;
    frame_tick_d = 1'b0;
    cur_nib      = 4'(disp_q >> {idx_q, 2'b00});
    // Digit i>0 goes dark when it and every higher nibble is zero.
    suppressed   = LZ_BLANK && (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'h0000);
    if (state_q == ST_SHOW) begin
      frame_tick_d = (idx_q == 2'd0) && (cnt_q == '0);
      if (!suppressed) begin
        enable_d = ~(4'b0001 << idx_q);
        out_d    = seg_decode(cur_nib);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q        <= 7'h7F;
      enable_q     <= 4'hF;
      frame_tick_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      enable_q     <= enable_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign out        = out_q;
  assign enable     = enable_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with REFRESH_DIV=4, BLANK_CYCLES=2, LZ_BLANK=1.
// Expected outputs come from frame-position arithmetic on the cycle count
// since reset release and are queued before each clock edge.
module tb_seg_scan_ctrl;

  localparam int unsigned RD    = 4;
  localparam int unsigned BC    = 2;
  localparam int unsigned SLOT  = RD + BC;
  localparam int unsigned FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [6:0]  out;
  logic [3:0]  enable;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  logic [11:0] exp_q[$];
  int unsigned ecount;
  logic [15:0] pend_m, disp_m;
  logic        dirty_m;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .LZ_BLANK    (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .din       (din),
    .hold      (hold),
    .out       (out),
    .enable    (enable),
    .frame_tick(frame_tick)
  );

  // Expected {out, enable, frame_tick} for scheduler cycle c showing value dv.
  function automatic logic [11:0] expect_for(input int unsigned c, input logic [15:0] dv);
    int unsigned p, slot, w;
    logic [15:0] sh;
    logic [3:0]  en;
    logic [3:0]  nib;
    if (c < BC) return {7'h7F, 4'hF, 1'b0};
    p    = (c - BC) % FRAME;
    slot = p / SLOT;
    w    = p % SLOT;
    if (w >= RD) return {7'h7F, 4'hF, 1'b0};
    sh = dv >> (4 * slot);
    if (slot != 0 && sh == 16'h0000) return {7'h7F, 4'hF, 1'b0};
    nib = sh[3:0];
    en = 4'hF;
    en[slot] = 1'b0;
    return {seg_tab[nib], en, (p == 0)};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed out=%h en=%h tick=%b, expected out=%h en=%h tick=%b",
             tag, obs[11:5], obs[4:1], obs[0], expv[11:5], expv[4:1], expv[0]);
    end
  endtask

  task automatic model_reset();
    ecount  = 0;
    pend_m  = 16'h0000;
    disp_m  = 16'h0000;
    dirty_m = 1'b0;
    exp_q.delete();
  endtask

  // One clock: drive inputs, queue expectation, advance model, compare after edge.
  task automatic step(input string tag, input logic ld, input logic [15:0] d, input logic hd);
    int unsigned edge_n;
    logic [11:0] e;
    load = ld;
    din  = d;
    hold = hd;
    edge_n = ecount + 1;
    exp_q.push_back(expect_for(edge_n - 1, disp_m));
    if (edge_n >= BC && ((edge_n - BC) % FRAME) == 0 && dirty_m) begin
      disp_m  = pend_m;
      dirty_m = 1'b0;
    end
    if (ld && !hd) begin
      pend_m  = d;
      dirty_m = 1'b1;
    end
    @(posedge clk);
    #1;
    ecount = edge_n;
    load = 1'b0;
    e = exp_q.pop_front();
    check(tag, {out, enable, frame_tick}, e);
  endtask

  initial begin
    bit found;
    model_reset();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", {out, enable, frame_tick}, {7'h7F, 4'hF, 1'b0});
    @(negedge clk) rst = 1'b1;

    // Idle after reset: only digit 0 lit, showing 0.
    repeat (FRAME + 4) step("idle", 1'b0, 16'h0000, 1'b0);

    // Mid-frame load appears from the next frame on.
    repeat (5) step("pre1234", 1'b0, 16'h0000, 1'b0);
    step("ld1234", 1'b1, 16'h1234, 1'b0);
    repeat (2 * FRAME) step("f1234", 1'b0, 16'h0000, 1'b0);

    // Leading-zero suppression of upper digits only.
    step("ld0050", 1'b1, 16'h0050, 1'b0);
    repeat (2 * FRAME) step("f0050", 1'b0, 16'h0000, 1'b0);

    // Hold blocks the load; releasing hold lets it through.
    step("hold_ld", 1'b1, 16'hBEEF, 1'b1);
    repeat (3 * FRAME) step("hold", 1'b0, 16'h0000, 1'b1);
    step("ldBEEF", 1'b1, 16'hBEEF, 1'b0);
    repeat (2 * FRAME) step("fBEEF", 1'b0, 16'h0000, 1'b0);

    // Two loads in one frame: only the last one is ever shown.
    for (int i = 0; i < FRAME && ((ecount - BC) % FRAME) != 3; i++)
      step("align1", 1'b0, 16'h0000, 1'b0);
    step("ld1111", 1'b1, 16'h1111, 1'b0);
    repeat (3) step("mid", 1'b0, 16'h0000, 1'b0);
    step("ld2222", 1'b1, 16'h2222, 1'b0);
    repeat (2 * FRAME) step("f2222", 1'b0, 16'h0000, 1'b0);

    // Load sampled on the boundary edge shows one frame later.
    for (int i = 0; i < FRAME && ((ecount + 1 - BC) % FRAME) != 0; i++)
      step("align2", 1'b0, 16'h0000, 1'b0);
    step("ld_bound", 1'b1, 16'h0C05, 1'b0);
    repeat (2 * FRAME) step("f0C05", 1'b0, 16'h0000, 1'b0);

    // Asynchronous reset during the digit-2 slot.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (((ecount - BC) % FRAME) == 13) begin
        found = 1'b1;
        break;
      end
      step("align3", 1'b0, 16'h0000, 1'b0);
    end
    tests++;
    if (!found) begin
      fails++;
      $error("FAIL align_digit2: observed not reached, expected digit-2 slot within %0d cycles", 2 * FRAME);
    end
    #1 rst = 1'b0;
    #1 check("async_rst", {out, enable, frame_tick}, {7'h7F, 4'hF, 1'b0});
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("rst_low", {out, enable, frame_tick}, {7'h7F, 4'hF, 1'b0});
    @(negedge clk) rst = 1'b1;
    repeat (FRAME + 4) step("post_rst", 1'b0, 16'h0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
